cpu_multicycle: RTL and testbench

Parametrised multi-cycle successor to the single-cycle `cpu` top level. It sequences each instruction through a FETCH/DECODE/EXECUTE/WRITEBACK state machine against a handshaked instruction-memory port, so fetch may take wait states. It adds a taken/not-taken branch and a HALT instruction, hardwires r0 to zero, and exposes a retire port for verification. It contains its own register bank and ALU and sits between the instruction memory and the rest of the design.

---
 rtl/cpu_multicycle.sv | 184 ++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU core. Each instruction passes through
// FETCH -> DECODE -> EXECUTE -> WRITEBACK. FETCH waits on a handshaked
// instruction-memory port. A HALT instruction parks the core until reset.
// r0 always reads as zero. Every completed instruction pulses the retire port.
module cpu_multicycle #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  retire_valid,
  output logic                  retire_we,
  output logic [REG_WIDTH-1:0]  retire_rd,
  output logic [WORD_SIZE-1:0]  retire_data
);

  localparam int NUM_REGS = 2 ** REG_WIDTH;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_LI   = 3'b011;
  localparam logic [2:0] OP_BNZ  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [31:0]            ir_q, ir_d;
  logic [WORD_SIZE-1:0]   a_q, a_d;          // r[rs1]
  logic [WORD_SIZE-1:0]   b_q, b_d;          // r[rs2]
  logic [WORD_SIZE-1:0]   c_q, c_d;          // r[rd], used as the branch condition
  logic [WORD_SIZE-1:0]   imm_q, imm_d;      // sign-extended immediate
  logic [WORD_SIZE-1:0]   result_q, result_d;
  logic [ADDR_WIDTH-1:0]  npc_q, npc_d;      // PC to commit at writeback
  logic [WORD_SIZE-1:0]   regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0]   regs_d [NUM_REGS];
  logic                   retire_valid_q, retire_valid_d;
  logic                   retire_we_q, retire_we_d;
  logic [REG_WIDTH-1:0]   retire_rd_q, retire_rd_d;
  logic [WORD_SIZE-1:0]   retire_data_q, retire_data_d;

  // Instruction fields; narrower register indices use only the low bits.
  logic [2:0]             op;
  logic [REG_WIDTH-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic signed [23:0]     imm24;
  logic                   op_writes;

  assign op        = ir_q[31:29];
  assign rd_idx    = ir_q[24 +: REG_WIDTH];
  assign rs1_idx   = ir_q[19 +: REG_WIDTH];
  assign rs2_idx   = ir_q[14 +: REG_WIDTH];
  assign imm24     = ir_q[23:0];
  assign op_writes = (op == OP_ADD) || (op == OP_SUB) || (op == OP_LI);

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign retire_valid = retire_valid_q;
  assign retire_we    = retire_we_q;
  assign retire_rd    = retire_rd_q;
  assign retire_data  = retire_data_q;

  // State register; reset aborts any state, including a pending fetch.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic: FETCH waits for ack, HALT is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (imem_ack) state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // State-decoded outputs, stable for the whole of a fetch wait.
  always_comb begin
    imem_req = (state_q == S_FETCH);
    halted   = (state_q == S_HALT);
  end

  // Datapath next values: each state touches only the registers it owns.
  always_comb begin
    pc_d          = pc_q;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    imm_d         = imm_q;
    result_d      = result_q;
    npc_d         = npc_q;
    regs_d        = regs_q;
    retire_valid_d = 1'b0;
    retire_we_d    = 1'b0;
    retire_rd_d    = '0;
    retire_data_d  = '0;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) ir_d = imem_data;
      end
      S_DECODE: begin
        a_d   = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
        b_d   = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];
        c_d   = (rd_idx  == '0) ? '0 : regs_q[rd_idx];
        imm_d = WORD_SIZE'(imm24);
      end
      S_EXECUTE: begin
        case (op)
          OP_ADD:  result_d = a_q + b_q;
          OP_SUB:  result_d = a_q - b_q;
          OP_LI:   result_d = imm_q;
          default: result_d = '0;  // non-writing ops report zero on retire
        endcase
        if ((op == OP_BNZ) && (c_q != '0))
          npc_d = pc_q + ADDR_WIDTH'($signed(imm_q));
        else
          npc_d = pc_q + ADDR_WIDTH'(1);
      end
      S_WRITEBACK: begin
        if (op_writes && (rd_idx != '0)) regs_d[rd_idx] = result_q;
        pc_d           = npc_q;
        retire_valid_d = 1'b1;
        retire_we_d    = op_writes && (rd_idx != '0);
        retire_rd_d    = rd_idx;
        retire_data_d  = result_q;
      end
      default: ;
    endcase
    regs_d[0] = '0;
  end

  // Datapath and register-bank flops; reset clears every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= '0;
      ir_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      c_q            <= '0;
      imm_q          <= '0;
      result_q       <= '0;
      npc_q          <= '0;
      regs_q         <= '{default: '0};
      retire_valid_q <= 1'b0;
      retire_we_q    <= 1'b0;
      retire_rd_q    <= '0;
      retire_data_q  <= '0;
    end else begin
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      a_q            <= a_d;
      b_q            <= b_d;
      c_q            <= c_d;
      imm_q          <= imm_d;
      result_q       <= result_d;
      npc_q          <= npc_d;
      regs_q         <= regs_d;
      retire_valid_q <= retire_valid_d;
      retire_we_q    <= retire_we_d;
      retire_rd_q    <= retire_rd_d;
      retire_data_q  <= retire_data_d;
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: directed programs plus random programs checked
// against an instruction-level model of the ISA, with a wait-state memory.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] pc;
  logic        halted;
  logic        retire_valid;
  logic        retire_we;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;

  cpu_multicycle #(.WORD_SIZE(32), .ADDR_WIDTH(32), .REG_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .pc(pc), .halted(halted),
    .retire_valid(retire_valid), .retire_we(retire_we),
    .retire_rd(retire_rd), .retire_data(retire_data)
  );

  initial forever #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- instruction memory responder ----------------
  logic [31:0] mem [256];
  int  wmin = 0, wmax = 0;
  bit  hold_low = 0;
  bit  in_fetch = 0;
  int  wait_left = 0, wait_cnt = 0;
  logic [31:0] fetch_addr = '0;
  int  waitq [$];

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        imem_ack = 1'b0;
        in_fetch = 0;
        waitq.delete();
      end else if (imem_req) begin
        if (!in_fetch) begin
          in_fetch   = 1;
          fetch_addr = imem_addr;
          wait_cnt   = 0;
          wait_left  = hold_low ? 1000000 : int'($urandom_range(wmax, wmin));
        end else begin
          check_eq("fetch_addr_stable", imem_addr, fetch_addr);
        end
        if (wait_left > 0) begin
          imem_ack  = 1'b0;
          imem_data = $urandom;
          wait_left--;
          wait_cnt++;
        end else begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr[7:0]];
          waitq.push_back(wait_cnt);
          in_fetch  = 0;
        end
      end else begin
        // Noise outside FETCH must be ignored by the core.
        imem_ack  = 1'($urandom_range(0, 1));
        imem_data = $urandom;
      end
    end
  end

  // ---------------- ISA-level reference model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0;
  endtask

  task automatic model_step(output logic e_we, output logic [4:0] e_rd,
                            output logic [31:0] e_data, output logic e_halt);
    logic [31:0] ins, imm, a, b, val;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        writes;
    ins = mem[m_pc[7:0]];
    op  = ins[31:29];
    rd  = ins[28:24];
    a   = m_regs[ins[23:19]];
    b   = m_regs[ins[18:14]];
    imm = {{8{ins[23]}}, ins[23:0]};
    writes = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
    val = (op == 3'd1) ? a + b : (op == 3'd2) ? a - b : (op == 3'd3) ? imm : 32'd0;
    e_we   = writes && (rd != 0);
    e_rd   = rd;
    e_data = val;
    e_halt = (op == 3'd5);
    if (e_we) m_regs[rd] = val;
    if (op == 3'd4 && m_regs[rd] != 0) m_pc = m_pc + imm;
    else                               m_pc = m_pc + 32'd1;
  endtask

  function automatic logic [31:0] enc_r(input logic [2:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 14'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [2:0] op, input logic [4:0] rd,
                                        input logic [23:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = enc_i(3'd5, 5'd0, 24'd0);
  endtask

  // ---------------- sequencing ----------------
  int fetch_start = 0;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_req", imem_req, 1);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_retire", {retire_valid, retire_we, retire_rd, retire_data}, 0);
    rst = 1'b0;
    model_reset();
    fetch_start = cyc;
  endtask

  task automatic run_prog(input int max_retire);
    int n = 0, budget = 3000, w;
    bit done = 0, hit_halt = 0, bad = 0;
    logic e_we, e_halt;
    logic [4:0] e_rd;
    logic [31:0] e_data;
    while (!done && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (retire_valid) begin
        model_step(e_we, e_rd, e_data, e_halt);
        check_eq("retire_we", retire_we, e_we);
        check_eq("retire_rd", retire_rd, e_rd);
        check_eq("retire_data", retire_data, e_data);
        check_eq("retire_pc", pc, m_pc);
        if (waitq.size() == 0) begin
          check_eq("retire_without_ack", 1, 0);
        end else begin
          w = waitq.pop_front();
          check_eq("latency", cyc - fetch_start, 4 + w);
        end
        fetch_start = cyc;
        if (e_halt) begin
          check_eq("halted_at_retire", {halted, imem_req}, 2'b10);
          hit_halt = 1;
        end else begin
          check_eq("next_fetch", {halted, imem_req, imem_addr}, {2'b01, m_pc});
        end
        n++;
        if (e_halt || n >= max_retire) done = 1;
      end
    end
    if (!done) check_eq("retire_timeout", 0, 1);
    if (hit_halt) begin
      repeat (20) begin
        @(posedge clk); #1;
        if (imem_req || !halted || retire_valid) bad = 1;
      end
      check_eq("halt_hold_20", bad, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // LI r1,5 with ack always ready: retire 4 cycles after the request.
    clear_mem();
    mem[0] = enc_i(3'd3, 5'd1, 24'd5);
    wmin = 0; wmax = 0;
    do_reset();
    run_prog(10);

    // Negative subtraction and immediate sign extension.
    clear_mem();
    mem[0] = enc_i(3'd3, 5'd1, 24'd2);
    mem[1] = enc_i(3'd3, 5'd2, 24'd5);
    mem[2] = enc_r(3'd2, 5'd3, 5'd1, 5'd2);
    mem[3] = enc_i(3'd3, 5'd4, 24'h800000);
    do_reset();
    run_prog(10);

    // Three wait states per fetch: 7-cycle latency.
    clear_mem();
    mem[0] = enc_i(3'd3, 5'd6, 24'h123456);
    mem[1] = enc_r(3'd1, 5'd7, 5'd6, 5'd6);
    wmin = 3; wmax = 3;
    do_reset();
    run_prog(10);

    // Countdown loop: branch taken once, then falls through to addr 4.
    clear_mem();
    mem[0] = enc_i(3'd3, 5'd1, 24'd2);
    mem[1] = enc_i(3'd3, 5'd2, 24'hFFFFFF);
    mem[2] = enc_r(3'd1, 5'd1, 5'd1, 5'd2);
    mem[3] = enc_i(3'd4, 5'd1, 24'hFFFFFF);
    mem[4] = enc_i(3'd0, 5'd0, 24'd0);
    wmin = 0; wmax = 2;
    do_reset();
    run_prog(20);

    // r0 is hardwired to zero.
    clear_mem();
    mem[0] = enc_i(3'd3, 5'd0, 24'd7);
    mem[1] = enc_r(3'd1, 5'd5, 5'd0, 5'd0);
    mem[2] = enc_i(3'd6, 5'd3, 24'h00ABCD);
    do_reset();
    run_prog(10);

    // Reset in the middle of a stalled fetch.
    clear_mem();
    mem[0] = enc_i(3'd3, 5'd1, 24'd5);
    mem[1] = enc_i(3'd3, 5'd2, 24'd6);
    wmin = 0; wmax = 0;
    do_reset();
    run_prog(1);
    hold_low = 1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("stall_req_addr", {imem_req, imem_addr}, {1'b1, 32'd1});
    end
    do_reset();
    hold_low = 0;
    run_prog(10);

    // Random programs with random wait states.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 256; i++) begin
        logic [31:0] w;
        w = $urandom;
        w[28:24] = 5'($urandom_range(0, 7));
        w[23:19] = 5'($urandom_range(0, 7));
        w[18:14] = 5'($urandom_range(0, 7));
        if (w[31:29] == 3'd5 && $urandom_range(0, 3) != 0) w[31:29] = 3'd3;
        if (w[31:29] == 3'd4) w[23:0] = 24'($urandom_range(0, 8)) - 24'd4;
        mem[i] = w;
      end
      wmin = 0; wmax = 3;
      do_reset();
      run_prog(40);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
